// File: rtl/uart_rx_pkg.sv
// Shared state encoding and supported oversampling ratios for the UART receive path.
// Pure declarations: no latency, no backpressure.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   function automatic logic is_supported_prescale(input logic [5:0] ps);
      return (ps == PRESCALE_8) || (ps == PRESCALE_16) || (ps == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Line, sampler and consumer signals of the UART frame controller (err_count only with UART_RX_ERR_CNT_EN).
// Wiring only: no latency, no backpressure (strobes are fire-and-forget).
interface uart_rx_fsm_if #(parameter int DATA_WIDTH = 8);

   logic                  RX_IN;
   logic [5:0]            prescale;
   logic                  PAR_EN;
   logic                  PAR_TYP;
   logic                  sampled_data;
   logic                  sampled_data_valid;
   logic                  data_sampler_enable;
   logic [5:0]            edge_count;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  parity_error;
   logic                  stop_error;
   logic                  start_glitch;
`ifdef UART_RX_ERR_CNT_EN
   logic [7:0]            err_count;

   modport master (
      input  RX_IN, prescale, PAR_EN, PAR_TYP, sampled_data, sampled_data_valid,
      output data_sampler_enable, edge_count, P_DATA, data_valid,
             parity_error, stop_error, start_glitch, err_count
   );
   modport slave (
      output RX_IN, prescale, PAR_EN, PAR_TYP, sampled_data, sampled_data_valid,
      input  data_sampler_enable, edge_count, P_DATA, data_valid,
             parity_error, stop_error, start_glitch, err_count
   );
`else
   modport master (
      input  RX_IN, prescale, PAR_EN, PAR_TYP, sampled_data, sampled_data_valid,
      output data_sampler_enable, edge_count, P_DATA, data_valid,
             parity_error, stop_error, start_glitch
   );
   modport slave (
      output RX_IN, prescale, PAR_EN, PAR_TYP, sampled_data, sampled_data_valid,
      input  data_sampler_enable, edge_count, P_DATA, data_valid,
             parity_error, stop_error, start_glitch
   );
`endif

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Tick-within-bit and bit-within-frame counters for the UART receive FSM.
// Wrap flag is combinational from the registered tick count; no backpressure.
module uart_rx_edge_bit_counter
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_run,
   input  logic       i_clr,
   input  logic       i_bit_clr,
   input  logic [5:0] i_prescale,
   output logic [5:0] o_edge_count,
   output logic       o_edge_wrap,
   output logic       o_bit_last
);

   logic [5:0] r_edge;
   logic [3:0] r_bit;
   logic [5:0] w_limit;

   assign w_limit = i_prescale - 6'd1;

   // >= rather than == so a mid-frame prescale drop still wraps on the next tick
   assign o_edge_wrap  = i_run && (r_edge >= w_limit);
   assign o_bit_last   = (r_bit == 4'(DATA_WIDTH - 1));
   assign o_edge_count = r_edge;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_edge <= '0;
         r_bit  <= '0;
      end else begin
         if (i_clr || !i_run || o_edge_wrap) begin
            r_edge <= '0;
         end else begin
            r_edge <= r_edge + 6'd1;
         end

         if (i_clr || i_bit_clr) begin
            r_bit <= '0;
         end else if (o_edge_wrap) begin
            r_bit <= r_bit + 4'd1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start/data/parity/stop sequencing, word assembly, error strobes (+err_count under UART_RX_ERR_CNT_EN).
// Strobes registered 1 cycle after the qualifying sampled_data_valid; no backpressure, consumer must take P_DATA on data_valid.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic          clk_based_on_prescale,
   input  logic          rst_n,
   uart_rx_fsm_if.master bus
);

   rx_state_t             r_state;
   logic                  r_enable;
   logic                  r_parity;
   logic                  r_sticky;
   logic                  r_data_valid;
   logic                  r_parity_error;
   logic                  r_stop_error;
   logic                  r_start_glitch;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [DATA_WIDTH-1:0] r_p_data;

   logic                  w_run;
   logic                  w_bit_clr;
   logic                  w_glitch;
   logic                  w_wrap;
   logic                  w_bit_last;
   logic [5:0]            w_edge_count;

   assign w_run     = (r_state != IDLE);
   assign w_bit_clr = (r_state != DATA);
   assign w_glitch  = (r_state == START) && bus.sampled_data_valid && bus.sampled_data;

   uart_rx_edge_bit_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
      .i_clk        (clk_based_on_prescale),
      .i_rst_n      (rst_n),
      .i_run        (w_run),
      .i_clr        (w_glitch),
      .i_bit_clr    (w_bit_clr),
      .i_prescale   (bus.prescale),
      .o_edge_count (w_edge_count),
      .o_edge_wrap  (w_wrap),
      .o_bit_last   (w_bit_last)
   );

   always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_enable       <= 1'b0;
         r_parity       <= 1'b0;
         r_sticky       <= 1'b0;
         r_data_valid   <= 1'b0;
         r_parity_error <= 1'b0;
         r_stop_error   <= 1'b0;
         r_start_glitch <= 1'b0;
         r_shift        <= '0;
         r_p_data       <= '0;
      end else begin
         r_data_valid   <= 1'b0;
         r_parity_error <= 1'b0;
         r_stop_error   <= 1'b0;
         r_start_glitch <= 1'b0;

         case (r_state)
            IDLE: begin
               if (!bus.RX_IN && is_supported_prescale(bus.prescale)) begin
                  r_state  <= START;
                  r_enable <= 1'b1;
                  r_sticky <= 1'b0;
                  r_parity <= 1'b0;
               end
            end
            START: begin
               if (w_glitch) begin
                  r_start_glitch <= 1'b1;
                  r_state        <= IDLE;
                  r_enable       <= 1'b0;
               end else if (w_wrap) begin
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (bus.sampled_data_valid) begin
                  r_shift  <= {bus.sampled_data, r_shift[DATA_WIDTH-1:1]};
                  r_parity <= r_parity ^ bus.sampled_data;
               end
               if (w_wrap && w_bit_last) begin
                  r_state <= bus.PAR_EN ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (bus.sampled_data_valid && ((r_parity ^ bus.PAR_TYP) != bus.sampled_data)) begin
                  r_parity_error <= 1'b1;
                  r_sticky       <= 1'b1;
               end
               if (w_wrap) begin
                  r_state <= STOP;
               end
            end
            STOP: begin
               if (bus.sampled_data_valid) begin
                  if (!bus.sampled_data) begin
                     r_stop_error <= 1'b1;
                  end else if (!r_sticky) begin
                     r_p_data     <= r_shift;
                     r_data_valid <= 1'b1;
                  end
               end
               if (w_wrap) begin
                  r_state  <= IDLE;
                  r_enable <= 1'b0;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_enable <= 1'b0;
            end
         endcase
      end
   end

   assign bus.data_sampler_enable = r_enable;
   assign bus.edge_count          = w_edge_count;
   assign bus.P_DATA              = r_p_data;
   assign bus.data_valid          = r_data_valid;
   assign bus.parity_error        = r_parity_error;
   assign bus.stop_error          = r_stop_error;
   assign bus.start_glitch        = r_start_glitch;

`ifdef UART_RX_ERR_CNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge clk_based_on_prescale or negedge rst_n) begin
      if (!rst_n) begin
         r_err_count <= '0;
      end else if ((r_parity_error || r_stop_error || r_start_glitch) && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign bus.err_count = r_err_count;
`endif

endmodule
